// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the parametrised Avalon-MM PIO.
//   - Register word addresses as seen on the 3-bit Avalon address bus.
//   - Edge-capture mode encodings used by the EDGE_TYPE parameter.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
  localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input synchroniser, previous-value register, arm counter
// and per-bit edge detector for the PIO input port.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   in_async  in   raw external inputs (IN_WIDTH)
//   sync_out  out  last synchroniser stage (IN_WIDTH)
//   edge_out  out  one-cycle edge pulses, gated by the arm counter (IN_WIDTH)
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] in_async,
  output logic [IN_WIDTH-1:0] sync_out,
  output logic [IN_WIDTH-1:0] edge_out
);

  // The arm counter must cover the whole synchroniser plus prev so that an
  // input already high at reset release never looks like an edge.
  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_q, sync_d;
  logic [IN_WIDTH-1:0]                  prev_q, prev_d;
  logic [IN_WIDTH-1:0]                  edge_raw;
  logic [2:0]                           arm_q, arm_d;
  logic                                 armed;

  always_comb begin
    // Stage 0 takes the raw input; higher stages shift up.
    sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
    prev_d = sync_q[SYNC_STAGES-1];
    armed  = (arm_q == 3'(ARM_MAX));
    arm_d  = armed ? arm_q : arm_q + 3'd1;

    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_raw = ~sync_q[SYNC_STAGES-1] & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_raw = sync_q[SYNC_STAGES-1] ^ prev_q;
    end else begin
      edge_raw = sync_q[SYNC_STAGES-1] & ~prev_q;
    end
    edge_out = armed ? edge_raw : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/avalon_pio_irq.sv
// avalon_pio_irq: Avalon-MM slave PIO with set/clear output register and a
// synchronised, edge-capturing, maskable-interrupt input port.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   address[2:0]          register word address
//   chipselect, write_n   write when chipselect && !write_n
//   writedata[31:0]       write data (bits above register width ignored)
//   readdata[31:0]        zero-wait-state read data
//   in_port[IN_WIDTH]     asynchronous external inputs
//   out_port[OUT_WIDTH]   registered outputs
//   irq                   level interrupt, active high
module avalon_pio_irq
  import pio_pkg::*;
#(
  parameter int                   OUT_WIDTH   = 8,
  parameter int                   IN_WIDTH    = 8,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET   = '0,
  parameter int                   EDGE_TYPE   = EDGE_RISING,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  logic [OUT_WIDTH-1:0] data_out_q, data_out_d, wd_out;
  logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
  logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
  logic [IN_WIDTH-1:0]  wd_in, w1c, sync_in, edge_vec;
  logic                 wr_en;

  pio_sync_edge #(
    .IN_WIDTH   (IN_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_async(in_port),
    .sync_out(sync_in),
    .edge_out(edge_vec)
  );

  always_comb begin
    wr_en      = chipselect & ~write_n;
    wd_out     = OUT_WIDTH'(writedata);
    wd_in      = IN_WIDTH'(writedata);
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    w1c        = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA_OUT: data_out_d = wd_out;
        ADDR_IRQ_MASK: irq_mask_d = wd_in;
        ADDR_EDGE_CAP: w1c        = wd_in;
        ADDR_OUT_SET:  data_out_d = data_out_q | wd_out;
        ADDR_OUT_CLR:  data_out_d = data_out_q & ~wd_out;
        default:       ;
      endcase
    end
    // OR-ing the new edges after the clear makes a same-cycle edge win.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_vec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= OUT_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA_OUT: readdata = 32'(data_out_q);
      ADDR_DATA_IN:  readdata = 32'(sync_in);
      ADDR_IRQ_MASK: readdata = 32'(irq_mask_q);
      ADDR_EDGE_CAP: readdata = 32'(edge_cap_q);
      default:       readdata = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: doc/avalon_pio_irq.md
Name: avalon_pio_irq

Overview:
Parametrised Avalon-MM slave PIO, successor to the fixed 2-bit audio-control output port.
- Output port: configurable width, plus atomic set/clear registers.
- Input port: configurable width, synchronised, with per-bit edge capture and a maskable interrupt.
- Sits on the Qsys/Platform Designer interconnect beside the CPU. Drives audio/codec control lines and collects status or button inputs.

Parameters:
OUT_WIDTH, 8, width of out_port (1..32)
IN_WIDTH, 8, width of in_port (1..32)
OUT_RESET, 0, reset value of the output register (OUT_WIDTH bits)
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge
SYNC_STAGES, 2, synchroniser depth on in_port (2..3)

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero-wait-state (combinational from address and registers)
in_port  in  IN_WIDTH  asynchronous external inputs
out_port  out  OUT_WIDTH  registered outputs
irq  out  1  level interrupt, active high

Behaviour:
- Reset is asynchronous and active-low. One clock domain (clk).
- Reset values:
  - data_out = OUT_RESET; out_port = OUT_RESET.
  - irq_mask = 0, edge_cap = 0, all synchroniser/previous registers = 0, arm counter = 0, irq = 0.
- Write occurs when chipselect && !write_n. Writedata bits above the register width are ignored.
- Register map:
  - 0 DATA_OUT, r/w: write loads data_out.
  - 1 DATA_IN, ro: synchronised input (last sync stage).
  - 2 IRQ_MASK, r/w, IN_WIDTH bits.
  - 3 EDGE_CAP, read / write-1-to-clear.
  - 4 OUT_SET, wo: data_out |= wd.
  - 5 OUT_CLR, wo: data_out &= ~wd.
  - 6, 7: reserved; writes ignored.
- Reads of 4..7, and all unused upper readdata bits, return 0.
- Write effects are visible on out_port and in readback from the cycle after the write edge.
- Synchroniser: SYNC_STAGES flops per bit. Previous register (prev) holds the last stage delayed by one clock.
- Edge detect, per bit, with sync = last sync stage:
  - rising: sync & ~prev
  - falling: ~sync & prev
  - any: sync ^ prev
- Latency with SYNC_STAGES=2: an in_port change stable before clock edge 1 sets edge_cap at edge 3.
- Arming:
  - A saturating arm counter counts SYNC_STAGES+1 clocks after reset release.
  - Edge detection is forced to 0 until the counter saturates.
  - This prevents spurious capture of inputs that are already high at reset.
- edge_cap update per bit: set on detected edge, otherwise cleared on W1C write.
- Simultaneous edge and W1C on the same bit: the set wins and the bit stays 1.
- Edge capture is independent of irq_mask; masked bits still capture.
- irq = |(edge_cap & irq_mask), combinational from registers.
  - irq asserts in the same cycle edge_cap or irq_mask becomes nonzero in the overlap.
  - irq deasserts the cycle after clearing.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. The arm sequence restarts on reset release.

Decomposition:
- Shared package pio_pkg:
  - Address constants ADDR_DATA_OUT .. ADDR_OUT_CLR.
  - Edge-type constants EDGE_RISING / EDGE_FALLING / EDGE_ANY.
- Sub-module pio_sync_edge (parameters IN_WIDTH, SYNC_STAGES, EDGE_TYPE) contains:
  - the synchroniser chain,
  - the prev register,
  - the arm counter.
  - Output: synchronised value and a one-cycle edge vector.
- The top level holds the register file, read mux and irq.

Test Plan:
1. Reset with OUT_RESET=8'hA5, then read addr 0 -> readdata=32'h000000A5, out_port=8'hA5, irq=0.
2. Write 0x0F to addr 0, then 0xF0 to addr 4, then 0x03 to addr 5 -> out_port sequence 0x0F, 0xFF, 0xFC; addr 4 reads 0.
3. EDGE_TYPE=0, mask=0x01, in_port[0] 0->1 -> edge_cap=0x01 at the 3rd clock edge; irq=1 the same cycle; addr 1 reads 0x01.
4. W1C 0x01 to addr 3 in the same cycle a new rising edge on bit 0 is detected -> edge_cap[0] stays 1 and irq stays 1. W1C with no edge -> edge_cap=0 and irq=0 next cycle.
5. in_port=0xFF held through reset release -> edge_cap stays 0 (arming suppresses). EDGE_TYPE=2 with bit 3 toggling 1->0 -> edge_cap=0x08.
6. Mask=0, capture on bit 2 -> irq=0. Then write mask 0x04 -> irq=1 the next cycle. Assert reset_n=0 mid-sequence -> irq, edge_cap and out_port return to reset values asynchronously.
